// File: rtl/led_sequencer.sv
// LED sequencer: DECODE of a select input, or a prescaled CHASE, BOUNCE or FILL
// animation across N_LEDS outputs. All outputs are registered.
module led_sequencer #(
   parameter int unsigned N_LEDS   = 7,
   parameter int unsigned PRESCALE = 4,
   localparam int unsigned IDX_W   = $clog2(N_LEDS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [IDX_W-1:0]  sel,
   output logic [N_LEDS-1:0] led,
   output logic [IDX_W-1:0]  pos,
   output logic              wrap
);

   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] PosLast = IDX_W'(N_LEDS - 1);

   typedef enum logic [1:0] {
      ModeDecode = 2'b00,
      ModeChase  = 2'b01,
      ModeBounce = 2'b10,
      ModeFill   = 2'b11
   } mode_e;

   typedef enum logic {
      DirUp   = 1'b0,
      DirDown = 1'b1
   } dir_e;

   mode_e             mode_q, mode_d;
   dir_e              dir_q, dir_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  pos_q, pos_d;
   logic [N_LEDS-1:0] led_q, led_d;
   logic              wrap_q, wrap_d;
   logic              tick;
   mode_e             mode_in;

   // Bit (sel-1) set for 1 <= sel <= N_LEDS; anything else lights nothing.
   function automatic logic [N_LEDS-1:0] decode(input logic [IDX_W-1:0] s);
      logic [N_LEDS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
         r[i] = (s == IDX_W'(i + 1));
      end
      return r;
   endfunction

   function automatic logic [N_LEDS-1:0] onehot(input logic [IDX_W-1:0] p);
      logic [N_LEDS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
         r[i] = (p == IDX_W'(i));
      end
      return r;
   endfunction

   function automatic logic [N_LEDS-1:0] thermo(input logic [IDX_W-1:0] p);
      logic [N_LEDS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
         r[i] = (IDX_W'(i) <= p);
      end
      return r;
   endfunction

   function automatic logic [N_LEDS-1:0] pattern(input mode_e m, input logic [IDX_W-1:0] p,
                                                 input logic [IDX_W-1:0] s);
      logic [N_LEDS-1:0] r;
      unique case (m)
         ModeDecode: r = decode(s);
         ModeFill:   r = thermo(p);
         default:    r = onehot(p);
      endcase
      return r;
   endfunction

   assign mode_in = mode_e'(mode);
   assign tick    = en && (cnt_q == CntLast);

   // Next-state: mode change beats everything, DECODE tracks sel, else prescaled stepping.
   always_comb begin
      mode_d = mode_q;
      dir_d  = dir_q;
      cnt_d  = cnt_q;
      pos_d  = pos_q;
      led_d  = led_q;
      wrap_d = 1'b0;
      if (mode_in != mode_q) begin
         // Any step due this cycle is discarded.
         mode_d = mode_in;
         dir_d  = DirUp;
         cnt_d  = '0;
         pos_d  = '0;
         led_d  = pattern(mode_in, '0, sel);
      end else if (mode_q == ModeDecode) begin
         cnt_d = '0;
         pos_d = '0;
         led_d = decode(sel);
      end else if (tick) begin
         cnt_d = '0;
         unique case (mode_q)
            ModeChase, ModeFill: begin
               if (pos_q == PosLast) begin
                  pos_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
            ModeBounce: begin
               if (N_LEDS == 1) begin
                  // A single LED has nowhere to go; every step is a full bounce.
                  pos_d  = '0;
                  wrap_d = 1'b1;
               end else if (dir_q == DirUp) begin
                  pos_d = pos_q + 1'b1;
                  if (pos_d == PosLast) dir_d = DirDown;
               end else begin
                  pos_d = pos_q - 1'b1;
                  if (pos_d == '0) begin
                     dir_d  = DirUp;
                     wrap_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
         led_d = pattern(mode_q, pos_d, sel);
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= ModeDecode;
         dir_q  <= DirUp;
         cnt_q  <= '0;
         pos_q  <= '0;
         led_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         dir_q  <= dir_d;
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         led_q  <= led_d;
         wrap_q <= wrap_d;
      end
   end

   assign led  = led_q;
   assign pos  = pos_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: expected outputs are queued as each step is
// driven and compared one cycle later, when the registered outputs appear.
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [2:0] sel;
   logic [6:0] led;
   logic [2:0] pos;
   logic       wrap;

   logic       sel1;
   logic [0:0] led1;
   logic [0:0] pos1;
   logic       wrap1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [6:0] led;
      logic [2:0] pos;
      logic       wrap;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   led_sequencer #(.N_LEDS(7), .PRESCALE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .sel   (sel),
      .led   (led),
      .pos   (pos),
      .wrap  (wrap)
   );

   led_sequencer #(.N_LEDS(1), .PRESCALE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .sel   (sel1),
      .led   (led1),
      .pos   (pos1),
      .wrap  (wrap1)
   );

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int l, input int p, input bit w);
      exp_t e;
      e.tag  = tag;
      e.led  = 7'(l);
      e.pos  = 3'(p);
      e.wrap = w;
      sb.push_back(e);
   endtask

   // Advance one edge, then compare the oldest queued expectation.
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      n_checks++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp({e.tag, " led"}, 32'(led), 32'(e.led));
         cmp({e.tag, " pos"}, 32'(pos), 32'(e.pos));
         cmp({e.tag, " wrap"}, 32'(wrap), 32'(e.wrap));
      end
   endtask

   function automatic int onehot(input int p);
      return 1 << p;
   endfunction

   function automatic int thermo(input int p);
      return (1 << (p + 1)) - 1;
   endfunction

   initial begin
      int ec;
      int p;
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 2'b00;
      sel   = 3'd0;
      sel1  = 1'b0;

      // Reset state, before and across a clock edge.
      #3;
      cmp("reset led", 32'(led), 32'd0);
      cmp("reset pos", 32'(pos), 32'd0);
      cmp("reset wrap", 32'(wrap), 32'd0);
      push("reset edge", 0, 0, 1'b0);
      cycle();
      rst_n = 1'b1;

      // DECODE sweep, one cycle latency.
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         push($sformatf("decode sel=%0d", s), (s == 0) ? 0 : onehot(s - 1), 0, 1'b0);
         cycle();
      end

      // CHASE: one step every 4 enabled cycles, wrap on 6->0.
      mode = 2'b01;
      en   = 1'b1;
      push("chase enter", 1, 0, 1'b0);
      cycle();
      for (int k = 1; k <= 28; k++) begin
         p = (k / 4) % 7;
         push($sformatf("chase k=%0d", k), onehot(p), p, k == 28);
         cycle();
      end

      // BOUNCE: up to 6, back down to 0, single wrap after 12 steps.
      mode = 2'b10;
      push("bounce enter", 1, 0, 1'b0);
      cycle();
      for (int k = 1; k <= 48; k++) begin
         p = k / 4;
         p = (p <= 6) ? p : 12 - p;
         push($sformatf("bounce k=%0d", k), onehot(p), p, k == 48);
         cycle();
      end

      // FILL with en dropped for 3 cycles mid-step; prescaler count must hold.
      mode = 2'b11;
      push("fill enter", 1, 0, 1'b0);
      cycle();
      ec = 0;
      for (int i = 0; i < 31; i++) begin
         en = !(i >= 2 && i < 5);
         if (en) ec++;
         p = (ec / 4) % 7;
         push($sformatf("fill i=%0d", i), thermo(p), p, en && ec == 28);
         cycle();
      end

      // CHASE to pos 4 on a tick cycle, then switch to FILL: step discarded.
      en   = 1'b1;
      mode = 2'b01;
      push("chase2 enter", 1, 0, 1'b0);
      cycle();
      for (int k = 1; k <= 19; k++) begin
         p = k / 4;
         push($sformatf("chase2 k=%0d", k), onehot(p), p, 1'b0);
         cycle();
      end
      mode = 2'b11;
      push("switch on tick", 1, 0, 1'b0);
      cycle();
      for (int k = 1; k <= 4; k++) begin
         p = k / 4;
         push($sformatf("after switch k=%0d", k), thermo(p), p, 1'b0);
         cycle();
      end

      // Reset pulsed between edges at pos 5.
      mode = 2'b01;
      push("chase3 enter", 1, 0, 1'b0);
      cycle();
      for (int k = 1; k <= 20; k++) begin
         p = k / 4;
         push($sformatf("chase3 k=%0d", k), onehot(p), p, 1'b0);
         cycle();
      end
      #1;
      rst_n = 1'b0;
      #1;
      cmp("async reset led", 32'(led), 32'd0);
      cmp("async reset pos", 32'(pos), 32'd0);
      cmp("async reset wrap", 32'(wrap), 32'd0);
      cmp("async reset led1", 32'(led1), 32'd0);
      push("in reset edge", 0, 0, 1'b0);
      cycle();
      rst_n = 1'b1;

      // First edge after release applies the CHASE mode change.
      push("post reset enter", 1, 0, 1'b0);
      cycle();
      cmp("n1 enter led", 32'(led1), 32'd1);
      cmp("n1 enter wrap", 32'(wrap1), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         p = k / 4;
         push($sformatf("post reset k=%0d", k), onehot(p), p, 1'b0);
         cycle();
         cmp($sformatf("n1 led k=%0d", k), 32'(led1), 32'd1);
         cmp($sformatf("n1 pos k=%0d", k), 32'(pos1), 32'd0);
         cmp($sformatf("n1 wrap k=%0d", k), 32'(wrap1), 32'd1);
      end
      en = 1'b0;
      push("hold en=0", 2, 1, 1'b0);
      cycle();
      cmp("n1 hold led", 32'(led1), 32'd1);
      cmp("n1 hold wrap", 32'(wrap1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
